// File: rtl/arrow_lane_scroller_pkg.sv
// Shared types and default lane geometry for the note-arrow scroller.
// Slot Y width is fixed here; the top's Y_W parameter defaults to it.
package arrow_pkg;

    localparam int SLOT_Y_W   = 10;
    localparam int LANE_X0    = 256;
    localparam int LANE_W     = 32;
    localparam int ARROW_HALF = 16;
    localparam int SPAWN_Y    = 464;
    localparam int TARGET_Y   = 32;

    typedef struct packed {
        logic                valid;
        logic [SLOT_Y_W-1:0] y;
    } slot_t;

endpackage

// File: rtl/arrow_lane_scroller_lane.sv
// One arrow lane: slot array, spawn allocation, hit selection, scroll/expire
// and the Y half of the draw mask.
module arrow_lane
    import arrow_pkg::*;
#(
    parameter int SLOTS      = 8,
    parameter int SPEED      = 2,
    parameter int SPAWN_Y    = arrow_pkg::SPAWN_Y,
    parameter int TARGET_Y   = arrow_pkg::TARGET_Y,
    parameter int HIT_WIN    = 8,
    parameter int ARROW_HALF = arrow_pkg::ARROW_HALF
) (
    input  logic                Clk,
    input  logic                reset,
    input  logic                i_tick,
    input  logic                i_spawn,
    input  logic                i_hit_req,
    input  logic [SLOT_Y_W-1:0] i_draw_y,
    output logic                o_y_match,
    output logic                o_hit_pulse,
    output logic                o_miss_pulse,
    output logic                o_overflow
);

    // Window compares carry one guard bit so the bounds never wrap.
    localparam logic [SLOT_Y_W:0]   WIN_LO     = (SLOT_Y_W+1)'(TARGET_Y - HIT_WIN);
    localparam logic [SLOT_Y_W:0]   WIN_HI     = (SLOT_Y_W+1)'(TARGET_Y + HIT_WIN);
    localparam logic [SLOT_Y_W:0]   MISS_BELOW = (SLOT_Y_W+1)'(TARGET_Y - HIT_WIN + SPEED);
    localparam logic [SLOT_Y_W:0]   HALF       = (SLOT_Y_W+1)'(ARROW_HALF);
    localparam logic [SLOT_Y_W-1:0] STEP       = SLOT_Y_W'(SPEED);
    localparam logic [SLOT_Y_W-1:0] SPAWN_POS  = SLOT_Y_W'(SPAWN_Y);

    slot_t               r_slot [SLOTS];
    slot_t               w_next [SLOTS];
    logic                r_hit;
    logic                r_miss;
    logic                r_ovf;
    logic                w_hit_found;
    logic                w_hit_take;
    int                  w_hit_idx;
    logic [SLOT_Y_W-1:0] w_best_y;
    logic                w_miss;
    logic                w_spawned;
    logic                w_drop;

    always_comb begin
        w_hit_found = 1'b0;
        w_hit_idx   = 0;
        w_best_y    = '1;
        // Strict '<' keeps the lowest index on equal Y.
        for (int j = 0; j < SLOTS; j++) begin
            if (r_slot[j].valid &&
                {1'b0, r_slot[j].y} >= WIN_LO && {1'b0, r_slot[j].y} <= WIN_HI &&
                (!w_hit_found || r_slot[j].y < w_best_y)) begin
                w_hit_found = 1'b1;
                w_hit_idx   = j;
                w_best_y    = r_slot[j].y;
            end
        end
        w_hit_take = i_hit_req && w_hit_found;

        w_miss = 1'b0;
        for (int j = 0; j < SLOTS; j++) begin
            w_next[j] = r_slot[j];
            if (w_hit_take && w_hit_idx == j) begin
                w_next[j].valid = 1'b0;
            end else if (i_tick && r_slot[j].valid) begin
                if ({1'b0, r_slot[j].y} < MISS_BELOW) begin
                    w_next[j].valid = 1'b0;
                    w_miss          = 1'b1;
                end else begin
                    w_next[j].y = r_slot[j].y - STEP;
                end
            end
        end

        // Allocation sees slots already freed by this cycle's hit or miss.
        w_spawned = 1'b0;
        w_drop    = 1'b0;
        if (i_tick && i_spawn) begin
            for (int j = 0; j < SLOTS; j++) begin
                if (!w_spawned && !w_next[j].valid) begin
                    w_next[j].valid = 1'b1;
                    w_next[j].y     = SPAWN_POS;
                    w_spawned       = 1'b1;
                end
            end
            w_drop = !w_spawned;
        end
    end

    always_comb begin
        o_y_match = 1'b0;
        for (int j = 0; j < SLOTS; j++) begin
            if (r_slot[j].valid &&
                ({1'b0, i_draw_y} + HALF >= {1'b0, r_slot[j].y}) &&
                ({1'b0, i_draw_y} <= {1'b0, r_slot[j].y} + HALF)) begin
                o_y_match = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < SLOTS; j++) begin
                r_slot[j] <= '0;
            end
            r_hit  <= 1'b0;
            r_miss <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            for (int j = 0; j < SLOTS; j++) begin
                r_slot[j] <= w_next[j];
            end
            r_hit  <= w_hit_take;
            r_miss <= w_miss;
            r_ovf  <= r_ovf | w_drop;
        end
    end

    assign o_hit_pulse  = r_hit;
    assign o_miss_pulse = r_miss;
    assign o_overflow   = r_ovf;

endmodule

// File: rtl/arrow_lane_scroller.sv
// Multi-lane note-arrow scroller: frame tick detect, lane X decode, lane array.
// Define ARROW_MISS_COUNT_EN to add per-lane saturating miss counters (miss_count).
module arrow_lane_scroller
    import arrow_pkg::*;
#(
    parameter int NUM_LANES      = 4,
    parameter int SLOTS_PER_LANE = 8,
    parameter int Y_W            = arrow_pkg::SLOT_Y_W,
    parameter int SPEED          = 2,
    parameter int SPAWN_Y        = arrow_pkg::SPAWN_Y,
    parameter int TARGET_Y       = arrow_pkg::TARGET_Y,
    parameter int HIT_WIN        = 8,
    parameter int LANE_X0        = arrow_pkg::LANE_X0,
    parameter int LANE_W         = arrow_pkg::LANE_W,
    parameter int ARROW_HALF     = arrow_pkg::ARROW_HALF
) (
    input  logic                 Clk,
    input  logic                 reset,
    input  logic                 frame_clk,
    input  logic [Y_W-1:0]       DrawX,
    input  logic [Y_W-1:0]       DrawY,
    input  logic [NUM_LANES-1:0] spawn,
    input  logic [NUM_LANES-1:0] hit_req,
    output logic [NUM_LANES-1:0] display_arrow,
    output logic [NUM_LANES-1:0] hit_pulse,
    output logic [NUM_LANES-1:0] miss_pulse,
    output logic [NUM_LANES-1:0] overflow
`ifdef ARROW_MISS_COUNT_EN
    ,
    output logic [NUM_LANES-1:0][7:0] miss_count
`endif
);

    logic                 r_frame_d;
    logic                 w_tick;
    logic [NUM_LANES-1:0] w_y_match;
    logic [NUM_LANES-1:0] w_x_in;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_frame_d <= 1'b0;
        end else begin
            r_frame_d <= frame_clk;
        end
    end

    assign w_tick = frame_clk & ~r_frame_d;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        localparam logic [Y_W:0] X_LO = (Y_W+1)'(LANE_X0 + g * LANE_W);
        localparam logic [Y_W:0] X_HI = (Y_W+1)'(LANE_X0 + (g + 1) * LANE_W);

        assign w_x_in[g]        = ({1'b0, DrawX} >= X_LO) && ({1'b0, DrawX} < X_HI);
        assign display_arrow[g] = w_x_in[g] & w_y_match[g];

        arrow_lane #(
            .SLOTS      (SLOTS_PER_LANE),
            .SPEED      (SPEED),
            .SPAWN_Y    (SPAWN_Y),
            .TARGET_Y   (TARGET_Y),
            .HIT_WIN    (HIT_WIN),
            .ARROW_HALF (ARROW_HALF)
        ) u_lane (
            .Clk          (Clk),
            .reset        (reset),
            .i_tick       (w_tick),
            .i_spawn      (spawn[g]),
            .i_hit_req    (hit_req[g]),
            .i_draw_y     (DrawY),
            .o_y_match    (w_y_match[g]),
            .o_hit_pulse  (hit_pulse[g]),
            .o_miss_pulse (miss_pulse[g]),
            .o_overflow   (overflow[g])
        );

`ifdef ARROW_MISS_COUNT_EN
        logic [7:0] r_miss_cnt;

        always_ff @(posedge Clk or posedge reset) begin
            if (reset) begin
                r_miss_cnt <= 8'd0;
            end else if (miss_pulse[g] && r_miss_cnt != 8'hFF) begin
                r_miss_cnt <= r_miss_cnt + 8'd1;
            end
        end

        assign miss_count[g] = r_miss_cnt;
`endif
    end

endmodule

// File: tb/tb_arrow_lane_scroller.sv
// Self-checking bench for arrow_lane_scroller: vector table, directed corner
// sequences and randomized traffic against a queue-based lane model.
module tb_arrow_lane_scroller;

    localparam int NL      = 4;
    localparam int SLOTS   = 4;
    localparam int SPEED   = 2;
    localparam int SPAWN_Y = 464;
    localparam int WIN_LO  = 32 - 8;
    localparam int WIN_HI  = 32 + 8;
    localparam int HALF    = 16;

    logic          Clk = 1'b0;
    logic          reset = 1'b1;
    logic          frame_clk = 1'b0;
    logic [9:0]    DrawX = '0;
    logic [9:0]    DrawY = '0;
    logic [NL-1:0] spawn = '0;
    logic [NL-1:0] hit_req = '0;
    logic [NL-1:0] display_arrow;
    logic [NL-1:0] hit_pulse;
    logic [NL-1:0] miss_pulse;
    logic [NL-1:0] overflow;
`ifdef ARROW_MISS_COUNT_EN
    logic [NL-1:0][7:0] miss_count;
`endif

    arrow_lane_scroller #(
        .NUM_LANES      (NL),
        .SLOTS_PER_LANE (SLOTS),
        .SPEED          (SPEED),
        .SPAWN_Y        (SPAWN_Y),
        .TARGET_Y       (32),
        .HIT_WIN        (8)
    ) dut (
        .Clk           (Clk),
        .reset         (reset),
        .frame_clk     (frame_clk),
        .DrawX         (DrawX),
        .DrawY         (DrawY),
        .spawn         (spawn),
        .hit_req       (hit_req),
        .display_arrow (display_arrow),
        .hit_pulse     (hit_pulse),
        .miss_pulse    (miss_pulse),
        .overflow      (overflow)
`ifdef ARROW_MISS_COUNT_EN
        ,
        .miss_count    (miss_count)
`endif
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // Reference model: each lane is just a bag of live arrow Y values.
    int            q [NL][$];
    logic [NL-1:0] m_ovf = '0;
    logic          m_frame_d = 1'b0;
    logic [NL-1:0] miss_seen = '0;
    int            m_misses0 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [NL-1:0] model_disp();
        logic [NL-1:0] d;
        int dx, dy;
        d  = '0;
        dx = int'(DrawX);
        dy = int'(DrawY);
        for (int l = 0; l < NL; l++) begin
            if (dx >= 256 + 32 * l && dx < 288 + 32 * l) begin
                for (int k = 0; k < q[l].size(); k++) begin
                    if (q[l][k] - HALF <= dy && dy <= q[l][k] + HALF) d[l] = 1'b1;
                end
            end
        end
        return d;
    endfunction

    task automatic model_clear();
        for (int l = 0; l < NL; l++) q[l].delete();
        m_ovf     = '0;
        m_frame_d = 1'b0;
        miss_seen = '0;
    endtask

    // One clock: advance the model on the current inputs, then check the DUT.
    task automatic cycle();
        logic          tk;
        logic [NL-1:0] e_hit;
        logic [NL-1:0] e_miss;
        tk     = frame_clk && !m_frame_d;
        e_hit  = '0;
        e_miss = '0;
        for (int l = 0; l < NL; l++) begin
            int best;
            int nq[$];
            best = -1;
            if (hit_req[l]) begin
                for (int k = 0; k < q[l].size(); k++) begin
                    if (q[l][k] >= WIN_LO && q[l][k] <= WIN_HI &&
                        (best < 0 || q[l][k] < q[l][best])) best = k;
                end
                if (best >= 0) begin
                    q[l].delete(best);
                    e_hit[l] = 1'b1;
                end
            end
            if (tk) begin
                for (int k = 0; k < q[l].size(); k++) begin
                    if (q[l][k] - SPEED < WIN_LO) e_miss[l] = 1'b1;
                    else nq.push_back(q[l][k] - SPEED);
                end
                q[l] = nq;
                if (spawn[l]) begin
                    if (q[l].size() < SLOTS) q[l].push_back(SPAWN_Y);
                    else m_ovf[l] = 1'b1;
                end
            end
        end
        m_frame_d = frame_clk;
        @(posedge Clk);
        #1;
        chk("hit_pulse", 32'(hit_pulse), 32'(e_hit));
        chk("miss_pulse", 32'(miss_pulse), 32'(e_miss));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("display", 32'(display_arrow), 32'(model_disp()));
        miss_seen = miss_seen | miss_pulse;
        if (e_miss[0]) m_misses0++;
    endtask

    task automatic tick_frame(input logic [NL-1:0] sp, input logic [NL-1:0] hr);
        frame_clk = 1'b1;
        spawn     = sp;
        hit_req   = hr;
        cycle();
        frame_clk = 1'b0;
        spawn     = '0;
        hit_req   = '0;
        cycle();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        frame_clk = 1'b0;
        spawn     = '0;
        hit_req   = '0;
        model_clear();
        @(posedge Clk);
        #1;
        chk("rst_hit", 32'(hit_pulse), 0);
        chk("rst_miss", 32'(miss_pulse), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_disp", 32'(display_arrow), 0);
        reset = 1'b0;
    endtask

    typedef struct {
        logic          fr;
        logic [NL-1:0] sp;
        logic [NL-1:0] hr;
        int            dx;
        int            dy;
        logic [NL-1:0] disp;
        logic [NL-1:0] hp;
        logic [NL-1:0] ov;
    } vec_t;

    vec_t vt[11];

    initial begin
        vt[0]  = '{1'b1, 4'b0001, 4'b0000, 270, 464, 4'b0001, 4'b0000, 4'b0000};
        vt[1]  = '{1'b0, 4'b0000, 4'b0000, 270, 480, 4'b0001, 4'b0000, 4'b0000};
        vt[2]  = '{1'b0, 4'b0000, 4'b0000, 270, 481, 4'b0000, 4'b0000, 4'b0000};
        vt[3]  = '{1'b1, 4'b0000, 4'b0000, 270, 446, 4'b0001, 4'b0000, 4'b0000};
        vt[4]  = '{1'b0, 4'b0000, 4'b0000, 270, 445, 4'b0000, 4'b0000, 4'b0000};
        vt[5]  = '{1'b0, 4'b0000, 4'b0000, 300, 462, 4'b0000, 4'b0000, 4'b0000};
        vt[6]  = '{1'b0, 4'b0000, 4'b0000, 287, 462, 4'b0001, 4'b0000, 4'b0000};
        vt[7]  = '{1'b0, 4'b0000, 4'b0000, 288, 462, 4'b0000, 4'b0000, 4'b0000};
        vt[8]  = '{1'b1, 4'b0010, 4'b0000, 300, 464, 4'b0010, 4'b0000, 4'b0000};
        vt[9]  = '{1'b0, 4'b0000, 4'b0001, 270, 460, 4'b0001, 4'b0000, 4'b0000};
        vt[10] = '{1'b0, 4'b0000, 4'b0000, 300, 447, 4'b0000, 4'b0000, 4'b0000};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            frame_clk = vt[i].fr;
            spawn     = vt[i].sp;
            hit_req   = vt[i].hr;
            DrawX     = 10'(vt[i].dx);
            DrawY     = 10'(vt[i].dy);
            cycle();
            chk($sformatf("vec%0d_disp", i), 32'(display_arrow), 32'(vt[i].disp));
            chk($sformatf("vec%0d_hit", i), 32'(hit_pulse), 32'(vt[i].hp));
            chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vt[i].ov));
        end
        frame_clk = 1'b0;
        spawn     = '0;
        hit_req   = '0;

        // Lane 1 arrow left alone until it scrolls out of the window.
        do_reset();
        DrawX = 10'd300;
        DrawY = 10'd8;
        tick_frame(4'b0010, 4'b0000);
        repeat (220) tick_frame(4'b0000, 4'b0000);
        #1 chk("A_y24_edge", 32'(display_arrow[1]), 1);
        DrawY = 10'd7;
        #1 chk("A_y24_below", 32'(display_arrow[1]), 0);
        DrawY = 10'd8;
        chk("A_no_early_miss", 32'(miss_seen[1]), 0);
        frame_clk = 1'b1;
        cycle();
        chk("A_miss_pulse", 32'(miss_pulse[1]), 1);
        frame_clk = 1'b0;
        cycle();
        chk("A_miss_once", 32'(miss_pulse[1]), 0);
        chk("A_slot_gone", 32'(display_arrow[1]), 0);

        // Lane 2: press outside the window, then inside it.
        do_reset();
        DrawX = 10'd330;
        DrawY = 10'd40;
        tick_frame(4'b0100, 4'b0000);
        repeat (211) tick_frame(4'b0000, 4'b0000);
        hit_req = 4'b0100;
        cycle();
        hit_req = '0;
        chk("B_hit_y42_none", 32'(hit_pulse[2]), 0);
        tick_frame(4'b0000, 4'b0000);
        chk("B_y40_drawn", 32'(display_arrow[2]), 1);
        hit_req = 4'b0100;
        cycle();
        hit_req = '0;
        chk("B_hit_pulse", 32'(hit_pulse[2]), 1);
        chk("B_hit_removed", 32'(display_arrow[2]), 0);
        cycle();
        chk("B_hit_once", 32'(hit_pulse[2]), 0);
        repeat (20) tick_frame(4'b0000, 4'b0000);
        chk("B_no_miss", 32'(miss_seen[2]), 0);

        // Lane 3: capacity overflow and reuse of a slot freed by a miss.
        do_reset();
        DrawX = 10'd360;
        DrawY = 10'd464;
        repeat (4) tick_frame(4'b1000, 4'b0000);
        chk("C_no_ovf_4", 32'(overflow[3]), 0);
        tick_frame(4'b1000, 4'b0000);
        chk("C_ovf_5th", 32'(overflow[3]), 1);
        repeat (216) tick_frame(4'b0000, 4'b0000);
        DrawY = 10'd480;
        #1 chk("C_no_live_spawn", 32'(display_arrow[3]), 0);
        frame_clk = 1'b1;
        spawn     = 4'b1000;
        cycle();
        chk("C_first_miss", 32'(miss_pulse[3]), 1);
        chk("C_respawn_drawn", 32'(display_arrow[3]), 1);
        chk("C_ovf_sticky", 32'(overflow[3]), 1);
        frame_clk = 1'b0;
        spawn     = '0;
        cycle();

        // Lane 0: press on a tick with two arrows in the window.
        do_reset();
        DrawX = 10'd260;
        tick_frame(4'b0001, 4'b0000);
        repeat (5) tick_frame(4'b0000, 4'b0000);
        tick_frame(4'b0001, 4'b0000);
        repeat (213) tick_frame(4'b0000, 4'b0000);
        frame_clk = 1'b1;
        hit_req   = 4'b0001;
        cycle();
        frame_clk = 1'b0;
        hit_req   = '0;
        chk("D_hit", 32'(hit_pulse[0]), 1);
        chk("D_no_miss", 32'(miss_pulse[0]), 0);
        DrawY = 10'd52;
        #1 chk("D_y36_top", 32'(display_arrow[0]), 1);
        DrawY = 10'd53;
        #1 chk("D_y36_above", 32'(display_arrow[0]), 0);
        DrawY = 10'd10;
        #1 chk("D_y26_removed", 32'(display_arrow[0]), 0);
        DrawY = 10'd36;
        cycle();
        @(posedge Clk);
        #3;
        reset = 1'b1;
        #1;
        chk("D_async_disp", 32'(display_arrow), 0);
        chk("D_async_ovf", 32'(overflow), 0);
        chk("D_async_pulses", 32'({hit_pulse, miss_pulse}), 0);
        model_clear();
        m_frame_d = frame_clk;

        // Randomized traffic against the lane model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            frame_clk = 1'($urandom_range(0, 1));
            spawn     = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            hit_req   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            DrawX     = 10'($urandom_range(240, 400));
            DrawY     = 10'($urandom_range(0, 500));
            cycle();
        end
        frame_clk = 1'b0;
        spawn     = '0;
        hit_req   = '0;

`ifdef ARROW_MISS_COUNT_EN
        do_reset();
        m_misses0 = 0;
        for (int i = 0; i < 20000 && m_misses0 < 300; i++) begin
            tick_frame(4'b0001, 4'b0000);
        end
        cycle();
        if (m_misses0 < 300) chk("E_miss_budget", 32'(m_misses0), 300);
        chk("E_miss_count_sat", 32'(miss_count[0]), 255);
        chk("E_miss_count_other", 32'(miss_count[1]), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
